// File: rtl/note_sequencer.sv
// 16-step programmable note sequencer: drives a note index and gate into the voice path.
// Optional swing timing is enabled by defining SEQ_SWING_EN.
module note_sequencer #(
  parameter int unsigned TICK_DIV = 8192,
  parameter int unsigned TICK_W   = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] tempo_in,
  input  logic [3:0] gate_len_in,
  input  logic [3:0] len_in,
  input  logic [1:0] swing_in,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [4:0] wr_data,
  output logic [3:0] note_out,
  output logic       gate_out,
  output logic [3:0] step_idx,
  output logic       step_strobe,
  output logic       running
);

  typedef enum logic {IDLE, RUN} state_e;

`ifdef SEQ_SWING_EN
  localparam int unsigned TC_W = 5;
`else
  localparam int unsigned TC_W = 4;
`endif

  state_e            state_q, state_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic [TC_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [TC_W-1:0]   last_tick;
  logic [3:0]        step_idx_q, step_idx_d;
  logic [3:0]        next_idx;
  logic [3:0]        note_q, note_d;
  logic              rest_q, rest_d;
  logic              strobe_q, strobe_d;
  logic [4:0]        pattern_q [16];
  logic [4:0]        pattern_d [16];

  // Index of the final tick of the current step (effective L-1).
  always_comb begin
`ifdef SEQ_SWING_EN
    if (!step_idx_q[0]) begin
      last_tick = {1'b0, tempo_in} + {3'b000, swing_in};
    end else if ({3'b000, swing_in} >= {1'b0, tempo_in}) begin
      last_tick = '0;
    end else begin
      last_tick = {1'b0, tempo_in} - {3'b000, swing_in};
    end
`else
    last_tick = tempo_in;
`endif
  end

  assign next_idx = (step_idx_q >= len_in) ? 4'd0 : step_idx_q + 4'd1;

  always_comb begin
    pattern_d = pattern_q;
    if (wr_en) begin
      pattern_d[wr_addr] = wr_data;
    end
  end

  // Reads use pattern_q, so a same-cycle write never affects the latched step.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    step_idx_d = step_idx_q;
    note_d     = note_q;
    rest_d     = rest_q;
    strobe_d   = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d    = RUN;
      presc_d    = '0;
      tick_cnt_d = '0;
      step_idx_d = 4'd0;
      note_d     = pattern_q[0][3:0];
      rest_d     = pattern_q[0][4];
      strobe_d   = 1'b1;
    end else if (state_q == RUN) begin
      if (presc_q == TICK_W'(TICK_DIV - 1)) begin
        presc_d = '0;
        if (tick_cnt_q == last_tick) begin
          tick_cnt_d = '0;
          step_idx_d = next_idx;
          note_d     = pattern_q[next_idx][3:0];
          rest_d     = pattern_q[next_idx][4];
          strobe_d   = 1'b1;
        end else begin
          tick_cnt_d = tick_cnt_q + TC_W'(1);
        end
      end else begin
        presc_d = presc_q + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      step_idx_q <= '0;
      note_q     <= '0;
      rest_q     <= 1'b0;
      strobe_q   <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        pattern_q[i] <= {2'b00, 3'(i)};
      end
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      step_idx_q <= step_idx_d;
      note_q     <= note_d;
      rest_q     <= rest_d;
      strobe_q   <= strobe_d;
      pattern_q  <= pattern_d;
    end
  end

  assign running     = (state_q == RUN);
  assign note_out    = note_q;
  assign step_idx    = step_idx_q;
  assign step_strobe = strobe_q;
  assign gate_out    = running & ~rest_q & (tick_cnt_q <= TC_W'(gate_len_in))
                     & (tick_cnt_q != last_tick);

endmodule

// File: tb/tb_note_sequencer.sv
// Directed self-checking bench for note_sequencer (TICK_DIV=4, default build).
module tb_note_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, wr_en;
  logic [3:0] tempo_in, gate_len_in, len_in, wr_addr;
  logic [1:0] swing_in;
  logic [4:0] wr_data;
  logic [3:0] note_out, step_idx;
  logic       gate_out, step_strobe, running;

  int vectors = 0;
  int miscompares = 0;
  int strobes;

  logic [3:0] exp_note [16];
  logic       exp_rest [16];

  note_sequencer #(.TICK_DIV(4), .TICK_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .tempo_in(tempo_in), .gate_len_in(gate_len_in), .len_in(len_in),
    .swing_in(swing_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .note_out(note_out), .gate_out(gate_out), .step_idx(step_idx),
    .step_strobe(step_strobe), .running(running)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each step lasts 16 cycles with tempo=3; gate high for ticks 0..2 (12 cycles) unless rest.
  task automatic play_steps(input int first, input int n, input int len);
    for (int k = 0; k < n; k++) begin
      int s;
      s = (first + k) % (len + 1);
      for (int c = 0; c < 16; c++) begin
        chk("step_idx", {4'h0, step_idx}, 8'(s));
        chk("note", {4'h0, note_out}, {4'h0, exp_note[s]});
        chk("strobe", {7'h0, step_strobe}, {7'h0, c == 0});
        chk("gate", {7'h0, gate_out}, {7'h0, (c < 12) && !exp_rest[s]});
        cycle();
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      exp_note[i] = 4'(i % 8);
      exp_rest[i] = 1'b0;
    end
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    tempo_in = 4'd3; gate_len_in = 4'd15; len_in = 4'd15; swing_in = 2'd0;
    wr_addr = 4'd0; wr_data = 5'd0;
    cycle(); cycle();
    chk("rst_note", {4'h0, note_out}, 8'h0);
    chk("rst_gate", {7'h0, gate_out}, 8'h0);
    chk("rst_idx", {4'h0, step_idx}, 8'h0);
    chk("rst_strobe", {7'h0, step_strobe}, 8'h0);
    chk("rst_running", {7'h0, running}, 8'h0);
    rst_n = 1'b1;
    cycle();
    chk("idle_running", {7'h0, running}, 8'h0);

    // Full pattern playback with 15->0 wrap.
    start = 1'b1; cycle(); start = 1'b0;
    chk("start_running", {7'h0, running}, 8'h1);
    play_steps(0, 17, 15);

    // Stop mid-gate during step 1.
    repeat (5) cycle();
    chk("pre_stop_gate", {7'h0, gate_out}, 8'h1);
    stop = 1'b1; cycle(); stop = 1'b0;
    chk("stop_running", {7'h0, running}, 8'h0);
    chk("stop_gate", {7'h0, gate_out}, 8'h0);
    chk("stop_idx", {4'h0, step_idx}, 8'h1);
    chk("stop_note", {4'h0, note_out}, 8'h1);
    chk("stop_strobe", {7'h0, step_strobe}, 8'h0);

    // Rest step 2 with note 9.
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 5'h19; cycle(); wr_en = 1'b0;
    exp_note[2] = 4'd9; exp_rest[2] = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    play_steps(0, 6, 15);

    // Shrink len during step 6: next step is 0 with a single strobe.
    repeat (3) cycle();
    len_in = 4'd3;
    strobes = 0;
    for (int i = 0; i < 13; i++) begin
      cycle();
      if (step_strobe) strobes++;
    end
    chk("len_strobes", 8'(strobes), 8'd1);
    chk("len_wrap_idx", {4'h0, step_idx}, 8'h0);
    chk("len_wrap_strobe", {7'h0, step_strobe}, 8'h1);
    play_steps(0, 5, 3);

    // Stop, then start+stop together from IDLE.
    stop = 1'b1; cycle(); stop = 1'b0;
    chk("stop2_running", {7'h0, running}, 8'h0);
    start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
    chk("ss_running", {7'h0, running}, 8'h0);
    chk("ss_strobe", {7'h0, step_strobe}, 8'h0);
    chk("ss_idx", {4'h0, step_idx}, 8'h1);
    cycle();
    chk("ss_strobe2", {7'h0, step_strobe}, 8'h0);
    chk("ss_running2", {7'h0, running}, 8'h0);

    // Overwrite step 5, then reset mid-step; reset restores the default pattern.
    len_in = 4'd15;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 5'h0C; cycle(); wr_en = 1'b0;
    exp_note[5] = 4'd12;
    start = 1'b1; cycle(); start = 1'b0;
    play_steps(0, 3, 15);
    cycle(); cycle();
    chk("pre_rst_running", {7'h0, running}, 8'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_note", {4'h0, note_out}, 8'h0);
    chk("arst_gate", {7'h0, gate_out}, 8'h0);
    chk("arst_idx", {4'h0, step_idx}, 8'h0);
    chk("arst_strobe", {7'h0, step_strobe}, 8'h0);
    chk("arst_running", {7'h0, running}, 8'h0);
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    for (int i = 0; i < 16; i++) begin
      exp_note[i] = 4'(i % 8);
      exp_rest[i] = 1'b0;
    end
    start = 1'b1; cycle(); start = 1'b0;
    play_steps(0, 6, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
